// File: rtl/board_state_writer_if.sv
// rtl/board_state_writer_if.sv - request, RAM write-port and status bundle for board_state_writer
//
// Purpose: groups the reveal/clear request side, the board-status RAM write
//          port and the game status outputs of board_state_writer.
// Ports (signals):
//   reveal, cell_x, cell_y   reveal request for cell (cell_x, cell_y)
//   clear                    request to rewrite the whole board to HIDDEN
//   mine_map                 bit i set = mine at cell i
//   wEn, addr, dataIn        RAM write port
//   busy, done               activity flag and reveal-handled pulse
//   game_over                sticky mine-revealed flag
//   revealed_count           cells revealed since the last clear
// Modports: master = requester / RAM side, slave = board_state_writer.

interface board_state_writer_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int NCELLS     = 25
);
    logic                  reveal;
    logic [2:0]            cell_x;
    logic [2:0]            cell_y;
    logic                  clear;
    logic [NCELLS-1:0]     mine_map;
    logic                  wEn;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] dataIn;
    logic                  busy;
    logic                  done;
    logic                  game_over;
    logic [4:0]            revealed_count;

    modport master (
        output reveal, cell_x, cell_y, clear, mine_map,
        input  wEn, addr, dataIn, busy, done, game_over, revealed_count
    );

    modport slave (
        input  reveal, cell_x, cell_y, clear, mine_map,
        output wEn, addr, dataIn, busy, done, game_over, revealed_count
    );
endinterface

// File: rtl/board_state_writer.sv
// rtl/board_state_writer.sv - write side of the 5x5 board-status RAM
//
// Purpose: clears the board to HIDDEN after reset or on request, and handles
//          reveal requests by counting neighbouring mines (one neighbour per
//          cycle) and writing the cell's status word at addr GRID_N*y+x.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous, active-high reset
//   bus    slave modport of board_state_writer_if (requests, RAM write port,
//          busy/done/game_over/revealed_count)

module board_state_writer #(
    parameter int GRID_N      = 5,
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int HIDDEN_CODE = 10,
    parameter int MINE_CODE   = 9
) (
    input  logic                clk,
    input  logic                reset,
    board_state_writer_if.slave bus
);
    localparam int NCELLS = GRID_N * GRID_N;

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_COUNT, S_WRITE} state_t;

    state_t            state_q, state_d;
    logic              run_q;
    logic [4:0]        index_q, index_d;
    logic [2:0]        cx_q, cx_d, cy_q, cy_d;
    logic [2:0]        nbr_q, nbr_d;
    logic [3:0]        count_q, count_d;
    logic [NCELLS-1:0] revealed_q, revealed_d;
    logic [4:0]        rcount_q, rcount_d;
    logic              game_over_q, game_over_d;
    logic              done_q, done_d;

    logic              wen_c, busy_c, go_clear;
    logic [4:0]        addr_c;
    logic [3:0]        code_c;

    // Zero-padded views so 5-bit cell indices never read past the map.
    logic [31:0] map_pad, rev_pad;
    assign map_pad = 32'(bus.mine_map);
    assign rev_pad = 32'(revealed_q);

    // Neighbour under test: offsets are 4-bit two's complement, so a step
    // off the left/top edge wraps to 15 and fails the range check.
    logic [3:0] dx, dy, nx, ny;
    logic [4:0] nb_cell;
    logic       nb_mine;

    always_comb begin
        dx = 4'd1;
        dy = 4'd1;
        case (nbr_q)
            3'd0:    begin dx = 4'hF; dy = 4'hF; end
            3'd1:    begin dx = 4'h0; dy = 4'hF; end
            3'd2:    begin dx = 4'h1; dy = 4'hF; end
            3'd3:    begin dx = 4'hF; dy = 4'h0; end
            3'd4:    begin dx = 4'h1; dy = 4'h0; end
            3'd5:    begin dx = 4'hF; dy = 4'h1; end
            3'd6:    begin dx = 4'h0; dy = 4'h1; end
            default: begin dx = 4'h1; dy = 4'h1; end
        endcase
    end

    assign nx      = {1'b0, cx_q} + dx;
    assign ny      = {1'b0, cy_q} + dy;
    assign nb_cell = 5'(ny) * 5'(GRID_N) + 5'(nx);
    assign nb_mine = (nx < 4'(GRID_N)) && (ny < 4'(GRID_N)) && map_pad[nb_cell];

    logic [4:0] req_cell;
    logic       req_ok;
    assign req_cell = 5'(bus.cell_y) * 5'(GRID_N) + 5'(bus.cell_x);
    assign req_ok   = (bus.cell_x < 3'(GRID_N)) && (bus.cell_y < 3'(GRID_N))
                      && !rev_pad[req_cell] && !game_over_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_CLEAR;
            run_q       <= 1'b0;
            index_q     <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            nbr_q       <= '0;
            count_q     <= '0;
            revealed_q  <= '0;
            rcount_q    <= '0;
            game_over_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= 1'b1;
            index_q     <= index_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            nbr_q       <= nbr_d;
            count_q     <= count_d;
            revealed_q  <= revealed_d;
            rcount_q    <= rcount_d;
            game_over_q <= game_over_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        nbr_d       = nbr_q;
        count_d     = count_q;
        revealed_d  = revealed_q;
        rcount_d    = rcount_q;
        game_over_d = game_over_q;
        done_d      = 1'b0;
        wen_c       = 1'b0;
        busy_c      = 1'b0;
        addr_c      = '0;
        code_c      = '0;
        go_clear    = 1'b0;

        case (state_q)
            S_CLEAR: begin
                // run_q holds the sweep off until the first edge after reset
                // release, keeping every output low while reset is asserted.
                busy_c = run_q;
                wen_c  = run_q;
                addr_c = index_q;
                code_c = 4'(HIDDEN_CODE);
                if (run_q) begin
                    if (bus.clear) begin
                        go_clear = 1'b1;
                    end else if (index_q == 5'(NCELLS - 1)) begin
                        state_d = S_IDLE;
                        index_d = '0;
                    end else begin
                        index_d = index_q + 5'd1;
                    end
                end
            end
            S_IDLE: begin
                if (bus.clear) begin
                    go_clear = 1'b1;
                end else if (bus.reveal) begin
                    if (req_ok) begin
                        state_d = S_COUNT;
                        index_d = req_cell;
                        cx_d    = bus.cell_x;
                        cy_d    = bus.cell_y;
                        nbr_d   = '0;
                        count_d = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_COUNT: begin
                busy_c = 1'b1;
                if (bus.clear) begin
                    go_clear = 1'b1;
                end else begin
                    count_d = count_q + {3'b0, nb_mine};
                    nbr_d   = nbr_q + 3'd1;
                    if (nbr_q == 3'd7) state_d = S_WRITE;
                end
            end
            default: begin // S_WRITE
                busy_c = 1'b1;
                if (bus.clear) begin
                    go_clear = 1'b1;
                end else begin
                    wen_c               = 1'b1;
                    addr_c              = index_q;
                    code_c              = map_pad[index_q] ? 4'(MINE_CODE) : count_q;
                    revealed_d[index_q] = 1'b1;
                    rcount_d            = rcount_q + 5'd1;
                    if (map_pad[index_q]) game_over_d = 1'b1;
                    state_d             = S_IDLE;
                    done_d              = 1'b1;
                end
            end
        endcase

        // A clear in any active state restarts the sweep and wipes progress;
        // the current cycle's cell write is dropped.
        if (go_clear) begin
            state_d     = S_CLEAR;
            index_d     = '0;
            revealed_d  = '0;
            rcount_d    = '0;
            game_over_d = 1'b0;
            done_d      = 1'b0;
            wen_c       = 1'b0;
            addr_c      = '0;
            code_c      = '0;
        end
    end

    assign bus.wEn            = wen_c;
    assign bus.addr           = ADDR_WIDTH'(addr_c);
    assign bus.dataIn         = DATA_WIDTH'(code_c);
    assign bus.busy           = busy_c;
    assign bus.done           = done_q;
    assign bus.game_over      = game_over_q;
    assign bus.revealed_count = rcount_q;
endmodule

// File: tb/tb_board_state_writer.sv
// tb/tb_board_state_writer.sv - directed self-checking bench for board_state_writer

module tb_board_state_writer;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    // Observations from the last reveal or clear sweep.
    int   w_n, w_k, w_addr, w_data, d_n, d_k;
    int   c_n, c_bad, c_busy_end, c_done;

    board_state_writer_if bus ();

    board_state_writer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue a reveal, then watch 14 cycles after the accepting edge.
    // k = 1 is the cycle right after that edge.
    task automatic do_reveal(input logic [2:0] x, input logic [2:0] y);
        @(negedge clk);
        bus.cell_x = x;
        bus.cell_y = y;
        bus.reveal = 1'b1;
        @(posedge clk);
        #1 bus.reveal = 1'b0;
        w_n = 0; w_k = -1; w_addr = -1; w_data = -1; d_n = 0; d_k = -1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (bus.wEn) begin
                w_n++;
                w_k    = k;
                w_addr = int'(bus.addr);
                w_data = int'(bus.dataIn);
            end
            if (bus.done) begin
                d_n++;
                if (d_k < 0) d_k = k;
            end
        end
    endtask

    // Watch 27 cycles of a clear sweep starting the cycle after the current edge.
    task automatic watch_clear();
        c_n = 0; c_bad = 0; c_busy_end = -1; c_done = 0;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            if (bus.wEn) begin
                if (int'(bus.addr) != c_n || bus.dataIn != 32'd10 || !bus.busy) c_bad++;
                c_n++;
            end
            if (bus.done) c_done++;
            if (i == 25) c_busy_end = int'(bus.busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.wEn, bus.busy, bus.done, bus.game_over} !== 4'b0 || bus.revealed_count !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs: wEn=%b busy=%b done=%b go=%b rc=%0d, required all 0",
                     bus.wEn, bus.busy, bus.done, bus.game_over, bus.revealed_count);
        end
        reset = 1'b0;
        watch_clear();
        checks++;
        if (c_n !== 25 || c_bad !== 0) begin
            errors++;
            $display("FAIL reset_sweep: writes=%0d bad=%0d, required writes=25 bad=0", c_n, c_bad);
        end
        checks++;
        if (c_busy_end !== 0 || c_done !== 0) begin
            errors++;
            $display("FAIL reset_sweep_end: busy=%0d done_pulses=%0d, required 0 0", c_busy_end, c_done);
        end
    endtask

    task automatic test_reveal_basic();
        bus.mine_map = 25'h23;
        do_reveal(3'd1, 3'd1);
        checks++;
        if (w_n !== 1 || w_k !== 9 || w_addr !== 6 || w_data !== 3) begin
            errors++;
            $display("FAIL reveal_1_1: writes=%0d cycle=%0d addr=%0d data=%0d, required 1 9 6 3",
                     w_n, w_k, w_addr, w_data);
        end
        checks++;
        if (d_n !== 1 || d_k !== 10 || bus.revealed_count !== 5'd1 || bus.game_over !== 1'b0) begin
            errors++;
            $display("FAIL reveal_1_1_done: pulses=%0d cycle=%0d rc=%0d go=%b, required 1 10 1 0",
                     d_n, d_k, bus.revealed_count, bus.game_over);
        end
    endtask

    task automatic test_reveal_edges();
        do_reveal(3'd4, 3'd4);
        checks++;
        if (w_n !== 1 || w_addr !== 24 || w_data !== 0) begin
            errors++;
            $display("FAIL reveal_4_4: writes=%0d addr=%0d data=%0d, required 1 24 0", w_n, w_addr, w_data);
        end
        do_reveal(3'd2, 3'd0);
        checks++;
        if (w_n !== 1 || w_k !== 9 || w_addr !== 2 || w_data !== 1) begin
            errors++;
            $display("FAIL reveal_2_0: writes=%0d cycle=%0d addr=%0d data=%0d, required 1 9 2 1",
                     w_n, w_k, w_addr, w_data);
        end
        checks++;
        if (bus.revealed_count !== 5'd3) begin
            errors++;
            $display("FAIL count_after_3: rc=%0d, required 3", bus.revealed_count);
        end
    endtask

    task automatic test_rejects();
        do_reveal(3'd1, 3'd1);
        checks++;
        if (w_n !== 0 || d_n !== 1 || d_k !== 1 || bus.revealed_count !== 5'd3) begin
            errors++;
            $display("FAIL repeat_reveal: writes=%0d pulses=%0d cycle=%0d rc=%0d, required 0 1 1 3",
                     w_n, d_n, d_k, bus.revealed_count);
        end
        do_reveal(3'd5, 3'd2);
        checks++;
        if (w_n !== 0 || d_n !== 1 || d_k !== 1) begin
            errors++;
            $display("FAIL out_of_range: writes=%0d pulses=%0d cycle=%0d, required 0 1 1", w_n, d_n, d_k);
        end
    endtask

    task automatic test_mine();
        do_reveal(3'd0, 3'd0);
        checks++;
        if (w_n !== 1 || w_addr !== 0 || w_data !== 9 || bus.game_over !== 1'b1 || bus.revealed_count !== 5'd4) begin
            errors++;
            $display("FAIL mine_0_0: writes=%0d addr=%0d data=%0d go=%b rc=%0d, required 1 0 9 1 4",
                     w_n, w_addr, w_data, bus.game_over, bus.revealed_count);
        end
        do_reveal(3'd3, 3'd3);
        checks++;
        if (w_n !== 0 || d_n !== 1 || d_k !== 1 || bus.game_over !== 1'b1) begin
            errors++;
            $display("FAIL after_game_over: writes=%0d pulses=%0d cycle=%0d go=%b, required 0 1 1 1",
                     w_n, d_n, d_k, bus.game_over);
        end
    endtask

    task automatic test_clear_request();
        @(negedge clk);
        bus.clear = 1'b1;
        @(posedge clk);
        #1 bus.clear = 1'b0;
        watch_clear();
        checks++;
        if (c_n !== 25 || c_bad !== 0 || c_busy_end !== 0 || c_done !== 0) begin
            errors++;
            $display("FAIL clear_request: writes=%0d bad=%0d busy_end=%0d done=%0d, required 25 0 0 0",
                     c_n, c_bad, c_busy_end, c_done);
        end
        checks++;
        if (bus.game_over !== 1'b0 || bus.revealed_count !== 5'd0) begin
            errors++;
            $display("FAIL clear_flags: go=%b rc=%0d, required 0 0", bus.game_over, bus.revealed_count);
        end
    endtask

    task automatic test_abort_count();
        int seen_w;
        do_reveal(3'd4, 3'd4);
        seen_w = 0;
        @(negedge clk);
        bus.cell_x = 3'd2;
        bus.cell_y = 3'd2;
        bus.reveal = 1'b1;
        @(posedge clk);
        #1 bus.reveal = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (bus.wEn) seen_w++;
        end
        bus.clear = 1'b1;
        @(posedge clk);
        #1 bus.clear = 1'b0;
        watch_clear();
        checks++;
        if (seen_w !== 0 || c_n !== 25 || c_bad !== 0 || c_done !== 0) begin
            errors++;
            $display("FAIL abort_count: early_writes=%0d writes=%0d bad=%0d done=%0d, required 0 25 0 0",
                     seen_w, c_n, c_bad, c_done);
        end
        checks++;
        if (bus.game_over !== 1'b0 || bus.revealed_count !== 5'd0) begin
            errors++;
            $display("FAIL abort_count_flags: go=%b rc=%0d, required 0 0", bus.game_over, bus.revealed_count);
        end
    endtask

    task automatic test_abort_write();
        @(negedge clk);
        bus.cell_x = 3'd0;
        bus.cell_y = 3'd4;
        bus.reveal = 1'b1;
        @(posedge clk);
        #1 bus.reveal = 1'b0;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1 bus.clear = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.wEn !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_write_cycle: wEn=%b busy=%b, required 0 1", bus.wEn, bus.busy);
        end
        @(posedge clk);
        #1 bus.clear = 1'b0;
        watch_clear();
        checks++;
        if (c_n !== 25 || c_bad !== 0 || c_done !== 0 || bus.revealed_count !== 5'd0) begin
            errors++;
            $display("FAIL abort_write: writes=%0d bad=%0d done=%0d rc=%0d, required 25 0 0 0",
                     c_n, c_bad, c_done, bus.revealed_count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.reveal = 1'b0;
        bus.cell_x = '0;
        bus.cell_y = '0;
        bus.clear = 1'b0;
        bus.mine_map = '0;
        test_reset();
        test_reveal_basic();
        test_reveal_edges();
        test_rejects();
        test_mine();
        test_clear_request();
        test_abort_count();
        test_abort_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
